// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read port between fetch and load refills.
// One INCR burst outstanding at a time; returning beats are steered to the granted requester.
module axi_rd_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_BEATS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_rvalid,
  output logic              inst_rlast,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic [ADDR_W-1:0] data_addr,
  output logic              data_rvalid,
  output logic              data_rlast,
  output logic [DATA_W-1:0] data_rdata,
  output logic              stallreq_axi,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic              rready
);

  localparam int CNT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner;   // 0 = inst, 1 = data
  logic              r_rr_ptr;  // 1 = data wins a tie
  logic [CNT_W-1:0]  r_beat_cnt;
  logic [ADDR_W-1:0] r_araddr;
  logic [3:0]        r_arid;

  logic w_grant;
  logic w_grant_owner;
  logic w_beat;
  logic w_at_last;
  logic w_arvalid;
  logic w_rready;

  assign w_grant_owner = (inst_req & data_req) ? r_rr_ptr : data_req;
  assign w_grant       = (r_state == S_IDLE) & (inst_req | data_req);
  assign w_beat        = (r_state == S_R) & rvalid;
  assign w_at_last     = (r_beat_cnt == LAST_BEAT);

  always_comb begin
    w_state_nxt = r_state;
    w_arvalid   = 1'b0;
    w_rready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) w_state_nxt = S_AR;
      end
      S_AR: begin
        w_arvalid = 1'b1;
        if (arready) w_state_nxt = S_R;
      end
      S_R: begin
        w_rready = 1'b1;
        // Burst length comes from the beat counter; AXI rlast is not consulted.
        if (rvalid && w_at_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner    <= 1'b0;
      r_rr_ptr   <= 1'b1;
      r_beat_cnt <= '0;
      r_araddr   <= '0;
      r_arid     <= '0;
    end else if (w_grant) begin
      r_owner    <= w_grant_owner;
      r_rr_ptr   <= ~w_grant_owner;
      r_beat_cnt <= '0;
      r_araddr   <= w_grant_owner ? data_addr : inst_addr;
      r_arid     <= {3'b000, w_grant_owner};
    end else if (w_beat) begin
      r_beat_cnt <= r_beat_cnt + CNT_W'(1);
    end
  end

  assign arvalid = w_arvalid;
  assign rready  = w_rready;
  assign araddr  = r_araddr;
  assign arid    = r_arid;
  assign arlen   = 8'(LINE_BEATS - 1);

  // Zero-latency steering of R beats to the current owner.
  assign inst_rdata  = rdata;
  assign data_rdata  = rdata;
  assign inst_rvalid = w_beat & ~r_owner;
  assign data_rvalid = w_beat &  r_owner;
  assign inst_rlast  = inst_rvalid & w_at_last;
  assign data_rlast  = data_rvalid & w_at_last;

  assign stallreq_axi = (inst_req & ~inst_rlast) | (data_req & ~data_rlast);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: per-scenario tasks plus a beat scoreboard fed by the R-channel driver.
module tb_axi_rd_arbiter;

  localparam int LB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, data_req, arready, rvalid;
  logic [31:0] inst_addr, data_addr, rdata;
  logic        inst_rvalid, inst_rlast, data_rvalid, data_rlast, stallreq_axi;
  logic        arvalid, rready;
  logic [31:0] inst_rdata, data_rdata, araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;

  typedef struct packed {
    logic        own;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .LINE_BEATS(LB)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rvalid(inst_rvalid),
    .inst_rlast(inst_rlast), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_rvalid(data_rvalid),
    .data_rlast(data_rlast), .data_rdata(data_rdata),
    .stallreq_axi(stallreq_axi), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every beat the DUT flags is matched against the next expected beat.
  always @(negedge clk) begin
    if ((inst_rlast && !inst_rvalid) || (data_rlast && !data_rvalid)) begin
      n_checks++;
      n_fail++;
      $display("FAIL rlast_without_rvalid: inst %0b/%0b data %0b/%0b", inst_rvalid, inst_rlast,
               data_rvalid, data_rlast);
    end
    if (inst_rvalid || data_rvalid) begin
      beat_t e;
      beat_t g;
      n_checks++;
      g.own  = data_rvalid;
      g.data = data_rvalid ? data_rdata : inst_rdata;
      g.last = data_rvalid ? data_rlast : inst_rlast;
      if (inst_rvalid && data_rvalid) begin
        n_fail++;
        $display("FAIL beat_both_owners: inst_rvalid=1 data_rvalid=1 required only one");
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL beat_unexpected: own=%0d data=%h last=%0b required no beat", g.own, g.data, g.last);
      end else begin
        e = exp_q.pop_front();
        if (g !== e)
          begin
            n_fail++;
            $display("FAIL beat: own=%0d data=%h last=%0b required own=%0d data=%h last=%0b",
                     g.own, g.data, g.last, e.own, e.data, e.last);
          end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic own, input int beat);
    beat_t e;
    rdata  = $urandom;
    e.own  = own;
    e.data = rdata;
    e.last = (beat == LB - 1);
    exp_q.push_back(e);
  endtask

  task automatic do_ar(output logic [3:0] id, output logic [31:0] addr, output int waited);
    waited = 0;
    while (!arvalid && waited < 20) begin
      tick();
      waited++;
    end
    if (!arvalid) begin
      n_checks++;
      n_fail++;
      $display("FAIL ar_timeout: arvalid=%0b after %0d cycles required 1", arvalid, waited);
    end
    id      = arid;
    addr    = araddr;
    arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  task automatic do_r(input logic own, input logic [15:0] pat);
    int beat = 0;
    int slot = 0;
    while (beat < LB && slot < 16) begin
      rvalid = pat[slot];
      if (rvalid) begin
        push_beat(own, beat);
        beat++;
      end
      tick();
      slot++;
    end
    rvalid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; inst_req = 1'b0; data_req = 1'b0; arready = 1'b0; rvalid = 1'b0;
    inst_addr = '0; data_addr = '0; rdata = '0;
    tick(); tick();
    n_checks++;
    if ({arvalid, rready, inst_rvalid, inst_rlast, data_rvalid, data_rlast, stallreq_axi} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: arvalid=%0b rready=%0b irv=%0b irl=%0b drv=%0b drl=%0b stall=%0b required all 0",
               arvalid, rready, inst_rvalid, inst_rlast, data_rvalid, data_rlast, stallreq_axi);
    end
    n_checks++;
    if (araddr !== 32'h0 || arid !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_ar: araddr=%h arid=%0d required 0/0", araddr, arid);
    end
    n_checks++;
    if (arlen !== 8'd3) begin
      n_fail++;
      $display("FAIL arlen: got %0d required 3", arlen);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_fetch();
    logic [3:0]  id;
    logic [31:0] addr;
    int          w;
    inst_addr = 32'h1C00_0000;
    inst_req  = 1'b1;
    #1;
    n_checks++;
    if (stallreq_axi !== 1'b1) begin
      n_fail++; $display("FAIL fetch_stall_on_req: got %0b required 1", stallreq_axi);
    end
    do_ar(id, addr, w);
    n_checks++;
    if (w !== 1 || id !== 4'd0 || addr !== 32'h1C00_0000) begin
      n_fail++; $display("FAIL fetch_ar: wait=%0d id=%0d addr=%h required 1/0/1c000000", w, id, addr);
    end
    n_checks++;
    if (arvalid !== 1'b0 || rready !== 1'b1) begin
      n_fail++; $display("FAIL fetch_ar_once: arvalid=%0b rready=%0b required 0/1", arvalid, rready);
    end
    do_r(1'b0, 16'hFFFF);
    inst_req = 1'b0;
    #1;
    n_checks++;
    if (stallreq_axi !== 1'b0 || rready !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL fetch_end: stall=%0b rready=%0b pending=%0d required 0/0/0",
                         stallreq_axi, rready, exp_q.size());
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0]  id;
    logic [31:0] addr;
    int          w;
    reset = 1'b1; tick(); reset = 1'b0;
    inst_addr = 32'h1C00_0040; data_addr = 32'h8000_1000;
    inst_req = 1'b1; data_req = 1'b1;
    do_ar(id, addr, w);
    n_checks++;
    if (id !== 4'd1 || addr !== 32'h8000_1000) begin
      n_fail++; $display("FAIL simul_first: id=%0d addr=%h required 1/80001000", id, addr);
    end
    do_r(1'b1, 16'hFFFF);
    data_req = 1'b0;
    do_ar(id, addr, w);
    n_checks++;
    if (w !== 1 || id !== 4'd0 || addr !== 32'h1C00_0040) begin
      n_fail++; $display("FAIL simul_second: wait=%0d id=%0d addr=%h required 1/0/1c000040", w, id, addr);
    end
    do_r(1'b0, 16'hFFFF);
    inst_req = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    data_addr = 32'h8000_2000;
    data_req  = 1'b1;
    arready   = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (arvalid !== 1'b1 || araddr !== 32'h8000_2000 || arid !== 4'd1) begin
        n_fail++; $display("FAIL bp_hold[%0d]: arvalid=%0b araddr=%h arid=%0d required 1/80002000/1",
                           i, arvalid, araddr, arid);
      end
      tick();
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    data_req = 1'b0;
    #1;
    n_checks++;
    if (arvalid !== 1'b0 || rready !== 1'b1 || stallreq_axi !== 1'b0) begin
      n_fail++; $display("FAIL bp_after: arvalid=%0b rready=%0b stall=%0b required 0/1/0",
                         arvalid, rready, stallreq_axi);
    end
    do_r(1'b1, 16'hFFFF);
    n_checks++;
    if (exp_q.size() != 0 || rready !== 1'b0) begin
      n_fail++; $display("FAIL bp_burst_end: pending=%0d rready=%0b required 0/0", exp_q.size(), rready);
    end
    tick();
  endtask

  task automatic test_rvalid_gaps();
    logic [3:0]  id;
    logic [31:0] addr;
    logic [6:0]  pat;
    int          w;
    int          beat;
    logic        stall_exp;
    pat = 7'b1011001;  // slot 0 is bit 0: 1,0,0,1,1,0,1
    inst_addr = 32'h1C00_0080;
    inst_req  = 1'b1;
    do_ar(id, addr, w);
    beat = 0;
    for (int s = 0; s < 7; s++) begin
      rvalid = pat[s];
      stall_exp = !(rvalid && beat == LB - 1);
      if (rvalid) begin
        push_beat(1'b0, beat);
        beat++;
      end
      #1;
      n_checks++;
      if (stallreq_axi !== stall_exp || rready !== 1'b1) begin
        n_fail++; $display("FAIL gaps_slot[%0d]: stall=%0b rready=%0b required %0b/1",
                           s, stallreq_axi, rready, stall_exp);
      end
      tick();
    end
    rvalid   = 1'b0;
    inst_req = 1'b0;
    #1;
    n_checks++;
    if (rready !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL gaps_end: rready=%0b pending=%0d required 0/0", rready, exp_q.size());
    end
    tick();
  endtask

  task automatic test_idle_rvalid();
    for (int i = 0; i < 3; i++) begin
      rvalid = 1'b1;
      rdata  = $urandom;
      #1;
      n_checks++;
      if (rready !== 1'b0 || inst_rvalid !== 1'b0 || data_rvalid !== 1'b0) begin
        n_fail++; $display("FAIL idle_rvalid[%0d]: rready=%0b irv=%0b drv=%0b required 0/0/0",
                           i, rready, inst_rvalid, data_rvalid);
      end
      tick();
    end
    rvalid = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0]  id;
    logic [31:0] addr;
    int          w;
    data_addr = 32'h8000_3000;
    data_req  = 1'b1;
    do_ar(id, addr, w);
    for (int b = 0; b < 2; b++) begin
      rvalid = 1'b1;
      push_beat(1'b1, b);
      tick();
    end
    rvalid = 1'b0;
    reset  = 1'b1;
    #1;
    n_checks++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || stallreq_axi !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid: arvalid=%0b rready=%0b stall=%0b required 0/0/1",
                         arvalid, rready, stallreq_axi);
    end
    data_req = 1'b0;
    #1;
    n_checks++;
    if (stallreq_axi !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_stall: got %0b required 0", stallreq_axi);
    end
    inst_addr = 32'h1C00_00C0;
    inst_req  = 1'b1;
    data_req  = 1'b1;
    tick();
    reset = 1'b0;
    do_ar(id, addr, w);
    n_checks++;
    if (w !== 1 || id !== 4'd1 || addr !== 32'h8000_3000) begin
      n_fail++; $display("FAIL rst_rr_ptr: wait=%0d id=%0d addr=%h required 1/1/80003000", w, id, addr);
    end
    do_r(1'b1, 16'hFFFF);
    data_req = 1'b0;
    inst_req = 1'b0;
    tick();
    n_checks++;
    if (arvalid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rst_after: arvalid=%0b pending=%0d required 0/0", arvalid, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  ids[3];
    int          waits[3];
    reset = 1'b1; tick(); reset = 1'b0;
    inst_addr = 32'h1C00_0100; data_addr = 32'h8000_4000;
    inst_req = 1'b1; data_req = 1'b1;
    do_ar(ids[0], addr, waits[0]);
    do_r(1'b1, 16'hFFFF);
    data_req = 1'b0;
    do_ar(ids[1], addr, waits[1]);
    data_addr = 32'h8000_4040;
    data_req  = 1'b1;
    do_r(1'b0, 16'hFFFF);
    do_ar(ids[2], addr, waits[2]);
    n_checks++;
    if (ids[0] !== 4'd1 || ids[1] !== 4'd0 || ids[2] !== 4'd1) begin
      n_fail++; $display("FAIL b2b_order: ids=%0d,%0d,%0d required 1,0,1", ids[0], ids[1], ids[2]);
    end
    n_checks++;
    if (waits[1] !== 1 || waits[2] !== 1 || addr !== 32'h8000_4040) begin
      n_fail++; $display("FAIL b2b_gap: waits=%0d,%0d addr=%h required 1,1/80004040",
                         waits[1], waits[2], addr);
    end
    do_r(1'b1, 16'hFFFF);
    data_req = 1'b0;
    inst_req = 1'b0;
    tick();
    id = arid;
    n_checks++;
    if (arvalid !== 1'b0 || exp_q.size() != 0 || id !== 4'd1) begin
      n_fail++; $display("FAIL b2b_end: arvalid=%0b pending=%0d arid=%0d required 0/0/1",
                         arvalid, exp_q.size(), id);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_backpressure();
    test_rvalid_gaps();
    test_idle_rvalid();
    test_reset_mid_burst();
    test_back_to_back();
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: pending=%0d required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
